// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared pixel/image geometry defaults and the line-server FSM
//               state encoding. Imported by framebuffer_line_server and by
//               pixel_cache so both agree on geometry and state values.
// Contents    : DEFAULT_PIXEL_WIDTH  - bits per pixel (RGB888)
//               DEFAULT_IMAGE_WIDTH  - pixels per scanline
//               DEFAULT_IMAGE_HEIGHT - scanlines per frame
//               line_state_e         - IDLE / ACK / STREAM / DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

  localparam int DEFAULT_PIXEL_WIDTH  = 24;
  localparam int DEFAULT_IMAGE_WIDTH  = 1920;
  localparam int DEFAULT_IMAGE_HEIGHT = 1080;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } line_state_e;

endpackage : pixel_pkg
`default_nettype wire

// File: rtl/framebuffer_line_server.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_line_server
// Description : Serves whole-scanline fetch requests from a pixel cache by
//               issuing one framebuffer read per pixel through an arbiter
//               grant and streaming the returned pixels back in x order.
//               A one-deep pending slot (last request wins) queues a request
//               that arrives while a line is in flight. Lines beyond the
//               frame height are answered with zero pixels and an error pulse.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               mem_req, mem_addr    - line request; line = mem_addr[31:16]
//               mem_ready            - one-cycle accept acknowledge
//               mem_pixel(_valid)    - pixel stream, no backpressure
//               fb_rd_en/addr        - framebuffer read request
//               fb_rd_gnt            - arbiter grant (issue = en & gnt)
//               fb_rd_data           - read data, one cycle after issue
//               busy, err_oob        - status
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_line_server
  import pixel_pkg::*;
#(
  parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH,
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int FB_ADDR_W    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req,
  input  logic [31:0]            mem_addr,
  output logic                   mem_ready,
  output logic [PIXEL_WIDTH-1:0] mem_pixel,
  output logic                   mem_pixel_valid,
  output logic                   fb_rd_en,
  output logic [FB_ADDR_W-1:0]   fb_rd_addr,
  input  logic                   fb_rd_gnt,
  input  logic [PIXEL_WIDTH-1:0] fb_rd_data,
  output logic                   busy,
  output logic                   err_oob
);

  // x counters must be able to hold IMAGE_WIDTH itself (the "done" value).
  localparam int             X_W    = $clog2(IMAGE_WIDTH + 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_WIDTH - 1);
  localparam logic [X_W-1:0] X_END  = X_W'(IMAGE_WIDTH);

  line_state_e           state_q, state_d;
  logic [15:0]           line_y_q, line_y_d;
  logic [FB_ADDR_W-1:0]  base_q, base_d;
  logic [X_W-1:0]        rd_x_q, rd_x_d;
  logic [X_W-1:0]        out_x_q, out_x_d;
  logic                  pending_q, pending_d;
  logic [15:0]           pend_y_q, pend_y_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  cur_oob;
  logic                  in_fetch;
  logic                  issue;
  logic                  zero_beat;
  logic                  advance;
  logic                  accept_live;
  logic                  accept_pend;
  logic                  accept;
  logic [15:0]           new_y;
  logic                  new_oob;
  logic [FB_ADDR_W-1:0]  new_base;
  logic                  unused_addr_lo;

  // Only the scanline index is meaningful; the low half of the address is
  // accepted for bus compatibility and deliberately dropped.
  assign unused_addr_lo = ^mem_addr[15:0];

  assign cur_oob  = (32'(line_y_q) >= 32'(IMAGE_HEIGHT));

  // Fetch window covers the ACK cycle (first read attempt) and STREAM.
  assign in_fetch  = ((state_q == ST_ACK) || (state_q == ST_STREAM)) &&
                     (rd_x_q < X_END);
  assign fb_rd_en  = in_fetch && !cur_oob;
  assign issue     = fb_rd_en && fb_rd_gnt;
  // Out-of-range lines stream zeros one per cycle, independent of the grant.
  assign zero_beat = in_fetch && cur_oob;
  assign advance   = issue || zero_beat;

  // base_q already holds y*IMAGE_WIDTH at full address width, so the sum
  // reaches the last legal word without truncation.
  assign fb_rd_addr = base_q + FB_ADDR_W'(rd_x_q);

  // A live request in IDLE supersedes whatever sits in the pending slot.
  assign accept_live = (state_q == ST_IDLE) && mem_req;
  assign accept_pend = (state_q == ST_IDLE) && !mem_req && pending_q;
  assign accept      = accept_live || accept_pend;
  assign new_y       = accept_live ? mem_addr[31:16] : pend_y_q;
  assign new_oob     = (32'(new_y) >= 32'(IMAGE_HEIGHT));
  assign new_base    = new_oob ? '0
                               : FB_ADDR_W'(32'(new_y) * 32'(IMAGE_WIDTH));

  always_comb begin
    state_d   = state_q;
    line_y_d  = line_y_q;
    base_d    = base_q;
    rd_x_d    = rd_x_q;
    out_x_d   = out_x_q;
    pending_d = pending_q;
    pend_y_d  = pend_y_q;
    valid_d   = advance;
    err_d     = 1'b0;

    if (advance) begin
      rd_x_d = rd_x_q + X_W'(1);
    end
    if (valid_q) begin
      out_x_d = out_x_q + X_W'(1);
    end

    // Requests arriving while a line is in flight park in the single slot;
    // a later one simply overwrites the parked line index.
    if ((state_q != ST_IDLE) && mem_req) begin
      pending_d = 1'b1;
      pend_y_d  = mem_addr[31:16];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_ACK;
          line_y_d  = new_y;
          base_d    = new_base;
          rd_x_d    = '0;
          out_x_d   = '0;
          pending_d = 1'b0;
          err_d     = new_oob;
        end
      end
      ST_ACK: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // The !in_fetch term covers a one-pixel line already issued in ACK.
        if (!in_fetch || (advance && (rd_x_q == X_LAST))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the final beat is on the output this cycle.
        if ((out_x_q + X_W'(valid_q)) == X_END) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_ACK);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      line_y_q  <= '0;
      base_q    <= '0;
      rd_x_q    <= '0;
      out_x_q   <= '0;
      pending_q <= 1'b0;
      pend_y_q  <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_y_q  <= line_y_d;
      base_q    <= base_d;
      rd_x_q    <= rd_x_d;
      out_x_q   <= out_x_d;
      pending_q <= pending_d;
      pend_y_q  <= pend_y_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign mem_ready       = ready_q;
  assign mem_pixel_valid = valid_q;
  // Gating keeps the bus at zero between beats and for out-of-range lines;
  // clearing valid_q in reset also discards data of an already issued read.
  assign mem_pixel       = (valid_q && !cur_oob) ? fb_rd_data : '0;
  assign busy            = busy_q;
  assign err_oob         = err_q;

endmodule : framebuffer_line_server
`default_nettype wire
